uart_tx_sequencer: RTL and testbench

Two-requester round-robin sequencer sitting in front of `uart_transmitter`. Each requester hands over a 32-bit word; the sequencer drives the transmitter's `Tx_DATA`/`Tx_WR`/`Tx_EN`/`baud_select` inputs to send it as four bytes, LSB byte first. It paces the byte writes off `Tx_BUSY` and reports completion or a transmitter timeout per word.

---
 rtl/uart_tx_sequencer.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// Two-requester round-robin front end for uart_transmitter. Each granted 32-bit word
// is sent as four LSB-first bytes, paced by Tx_BUSY, with a per-byte handshake timeout.
module uart_tx_sequencer #(
    parameter int         TIMEOUT      = 16,
    parameter logic [2:0] BAUD_DEFAULT = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  baud_cfg,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [31:0] word_a,
    input  logic [31:0] word_b,
    output logic        done_a,
    output logic        done_b,
    output logic        timeout_err,
    output logic        seq_busy,
    output logic [7:0]  Tx_DATA,
    output logic        Tx_WR,
    output logic        Tx_EN,
    output logic [2:0]  baud_select,
    input  logic        Tx_BUSY
);
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_word;
    logic [1:0]       r_byte_idx;
    logic             r_owner;       // 1 = requester B
    logic             r_last_grant;  // 1 = requester B
    logic             r_abort;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tx_data;
    logic [2:0]       r_baud;
    logic             r_tx_en;
    logic             r_seq_busy;

    logic             w_grant;
    logic             w_grant_b;
    logic             w_advance;
    logic             w_cnt_hit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [31:0]      w_word_in;

    assign w_word_in = w_grant_b ? word_b : word_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_b = 1'b0;
        w_advance = 1'b0;
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_cnt_hit = (w_cnt_inc == CNT_LIMIT);
        case (r_state)
            S_IDLE: begin
                if (en && (req_a || req_b)) begin
                    w_grant   = 1'b1;
                    // On a tie the requester that was not served last wins
                    w_grant_b = req_b && (!req_a || !r_last_grant);
                    w_next    = S_STROBE;
                end
            end
            S_STROBE: w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (Tx_BUSY)        w_next = S_WAIT_IDLE;
                else if (w_cnt_hit) w_next = S_DONE;
            end
            S_WAIT_IDLE: begin
                if (!Tx_BUSY) begin
                    if (r_byte_idx == 2'd3) begin
                        w_next = S_DONE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = S_STROBE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_idx   <= 2'd0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_abort      <= 1'b0;
            r_cnt        <= '0;
            r_tx_data    <= 8'h00;
            r_baud       <= BAUD_DEFAULT;
            r_tx_en      <= 1'b0;
            r_seq_busy   <= 1'b0;
        end else begin
            r_tx_en <= en;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_tx_data  <= w_word_in[7:0];
                        r_baud     <= baud_cfg;
                        r_byte_idx <= 2'd0;
                        r_owner    <= w_grant_b;
                        r_abort    <= 1'b0;
                        r_seq_busy <= 1'b1;
                    end
                end
                S_STROBE: r_cnt <= '0;
                S_WAIT_BUSY: begin
                    if (!Tx_BUSY) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_hit) r_abort <= 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    // Next byte is loaded only once the transmitter is idle again
                    if (w_advance) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_tx_data  <= r_word[15:8];
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_owner;
                    r_seq_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Hold register shifts right so the outgoing byte is always r_word[7:0]
    always_ff @(posedge clk) begin
        if (w_grant)        r_word <= w_word_in;
        else if (w_advance) r_word <= {8'h00, r_word[31:8]};
    end

    assign Tx_WR       = (r_state == S_STROBE);
    assign done_a      = (r_state == S_DONE) && !r_owner;
    assign done_b      = (r_state == S_DONE) && r_owner;
    assign timeout_err = (r_state == S_DONE) && r_abort;
    assign seq_busy    = r_seq_busy;
    assign Tx_DATA     = r_tx_data;
    assign Tx_EN       = r_tx_en;
    assign baud_select = r_baud;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: stimulus queues expected bytes/completions,
// a negedge monitor compares them against Tx_WR and done_* as they appear.
module tb_uart_tx_sequencer;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  baud_cfg;
    logic        req_a, req_b;
    logic [31:0] word_a, word_b;
    logic        done_a, done_b, timeout_err, seq_busy;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR, Tx_EN;
    logic [2:0]  baud_select;
    logic        Tx_BUSY;

    always #5 clk = ~clk;

    uart_tx_sequencer #(.TIMEOUT(TIMEOUT), .BAUD_DEFAULT(3'b010)) dut (
        .clk(clk), .reset(reset), .en(en), .baud_cfg(baud_cfg),
        .req_a(req_a), .req_b(req_b), .word_a(word_a), .word_b(word_b),
        .done_a(done_a), .done_b(done_b), .timeout_err(timeout_err), .seq_busy(seq_busy),
        .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN), .baud_select(baud_select),
        .Tx_BUSY(Tx_BUSY)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic [2:0] baud;
        logic [7:0] data;
    } byte_exp_t;

    typedef struct packed {
        logic owner;  // 1 = B
        logic to;
    } done_exp_t;

    byte_exp_t exp_bytes[$];
    done_exp_t exp_done[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit m_last_b = 1'b1;
    bit tx_dead  = 1'b0;
    int tx_blen  = 0;
    int tx_dly_v, tx_blen_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Round-robin rule: tie goes to the requester not served last
    function automatic bit pick(input bit ra, input bit rb);
        if (ra && rb) return !m_last_b;
        return rb;
    endfunction

    function automatic void push_word(input bit owner_b, input logic [31:0] w,
                                      input logic [2:0] baud, input bit to);
        byte_exp_t e;
        done_exp_t d;
        for (int i = 0; i < 4; i++) begin
            e.idx  = 2'(i);
            e.baud = baud;
            e.data = w[8*i +: 8];
            exp_bytes.push_back(e);
            if (to) break;
        end
        d.owner = owner_b;
        d.to    = to;
        exp_done.push_back(d);
        m_last_b = owner_b;
    endfunction

    // Transmitter model: busy for a while after each accepted write
    initial begin
        Tx_BUSY = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (Tx_WR && !tx_dead) begin
                tx_dly_v  = (tx_blen > 0) ? 0 : int'($urandom_range(0, 4));
                tx_blen_v = (tx_blen > 0) ? tx_blen : int'($urandom_range(1, 12));
                repeat (tx_dly_v) begin @(posedge clk); #1; end
                Tx_BUSY = 1'b1;
                repeat (tx_blen_v) begin @(posedge clk); #1; end
                Tx_BUSY = 1'b0;
            end
        end
    end

    int          cyc = 0, wr_cyc = 0, fall_cyc = -100;
    bit          prev_busy = 1'b0, stab_arm = 1'b0;
    logic [7:0]  last_byte;
    logic [2:0]  last_baud;

    always @(negedge clk) begin
        byte_exp_t e;
        done_exp_t d;
        cyc++;
        if (!reset) stab_arm = 1'b0;
        if (prev_busy && !Tx_BUSY) fall_cyc = cyc;
        prev_busy = Tx_BUSY;
        if (Tx_WR) begin
            if (exp_bytes.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got Tx_DATA %0h, expected no strobe", Tx_DATA);
            end else begin
                e = exp_bytes.pop_front();
                chk("tx_data", Tx_DATA, e.data);
                chk("baud_select", baud_select, e.baud);
                chk("busy_at_strobe", seq_busy, 1);
                if (e.idx != 2'd0) chk("byte_gap", cyc, fall_cyc + 1);
            end
            wr_cyc    = cyc;
            last_byte = Tx_DATA;
            last_baud = baud_select;
            stab_arm  = 1'b1;
        end
        if (Tx_BUSY && stab_arm) begin
            chk("data_stable", Tx_DATA, last_byte);
            chk("baud_stable", baud_select, last_baud);
        end
        if (done_a || done_b || timeout_err) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done_a=%0b done_b=%0b timeout_err=%0b, expected none",
                         done_a, done_b, timeout_err);
            end else begin
                d = exp_done.pop_front();
                chk("done_owner", {done_b, done_a}, d.owner ? 2'b10 : 2'b01);
                chk("timeout_err", timeout_err, d.to);
                chk("busy_at_done", seq_busy, 1);
                if (d.to) chk("timeout_latency", cyc - wr_cyc, TIMEOUT + 1);
                else      chk("done_latency", cyc, fall_cyc + 1);
            end
        end
    end

    task automatic wait_done(output logic ga, output logic gb);
        int t;
        ga = 1'b0;
        gb = 1'b0;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done_a || done_b) break;
        end
        if (t == 3000) begin
            n_checks++;
            $display("FAIL wait_done: no done within 3000 cycles, expected one");
        end else begin
            ga = done_a;
            gb = done_b;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_pair(input bit ra, input bit rb, input logic [31:0] wa,
                            input logic [31:0] wb, input logic [2:0] baud, input bit to);
        bit   first;
        int   n;
        logic ga, gb;
        word_a   = wa;
        word_b   = wb;
        baud_cfg = baud;
        first    = pick(ra, rb);
        push_word(first, first ? wb : wa, baud, to);
        n = 1;
        if (ra && rb) begin
            push_word(!first, first ? wa : wb, baud, to);
            n = 2;
        end
        req_a = ra;
        req_b = rb;
        @(posedge clk); #1;
        if (first) word_b = $urandom;
        else       word_a = $urandom;
        for (int k = 0; k < n; k++) begin
            wait_done(ga, gb);
            if (ga) req_a = 1'b0;
            if (gb) req_b = 1'b0;
            if (!ga && !gb) break;
        end
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic        ga, gb;
        logic [1:0]  pat;
        int          nwr;
        reset = 1'b0; en = 1'b1; baud_cfg = 3'b000;
        req_a = 1'b0; req_b = 1'b0; word_a = '0; word_b = '0;
        #12;
        chk("rst_tx_wr", Tx_WR, 0);
        chk("rst_tx_data", Tx_DATA, 0);
        chk("rst_tx_en", Tx_EN, 0);
        chk("rst_baud", baud_select, 3'b010);
        chk("rst_done", {done_b, done_a, timeout_err}, 0);
        chk("rst_seq_busy", seq_busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Tie from reset: A, B, A with both requests held
        tx_blen  = 6;
        baud_cfg = 3'b101;
        word_a   = 32'h1122_3344;
        word_b   = 32'h5566_7788;
        push_word(pick(1, 1), 32'h1122_3344, 3'b101, 0);
        push_word(pick(1, 1), 32'h5566_7788, 3'b101, 0);
        push_word(pick(1, 1), 32'h99AA_BBCC, 3'b101, 0);
        req_a = 1'b1;
        req_b = 1'b1;
        @(negedge clk); chk("grant_latency_pre", Tx_WR, 0);
        @(negedge clk); chk("grant_latency", Tx_WR, 1);
        @(posedge clk); #1;
        word_a = 32'h99AA_BBCC;
        for (int k = 0; k < 3; k++) wait_done(ga, gb);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Single word with a 20-cycle busy transmitter
        tx_blen = 20;
        run_pair(1, 0, 32'hA5C3_6C36, 32'h0, 3'b010, 0);

        // Transmitter never answers
        tx_dead = 1'b1;
        run_pair(1, 0, $urandom, 32'h0, 3'b011, 1);
        repeat (10) begin @(posedge clk); #1; end
        tx_dead = 1'b0;

        // Enable gating
        tx_blen = 0;
        en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        w = $urandom;
        word_b   = w;
        baud_cfg = 3'b110;
        push_word(pick(0, 1), w, 3'b110, 0);
        req_b = 1'b1;
        repeat (6) @(negedge clk);
        chk("en_off_tx_en", Tx_EN, 0);
        chk("en_off_seq_busy", seq_busy, 0);
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk); chk("tx_en_delay", Tx_EN, 0);
        @(negedge clk); chk("tx_en_on", Tx_EN, 1);
        chk("en_grant", Tx_WR, 1);
        @(posedge clk); #1;
        wait_done(ga, gb);
        req_b = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset during WAIT_IDLE of byte 2
        tx_blen  = 5;
        w        = $urandom;
        word_a   = w;
        baud_cfg = 3'b001;
        push_word(pick(1, 0), w, 3'b001, 0);
        req_a = 1'b1;
        nwr = 0;
        for (int t = 0; t < 2000 && nwr < 3; t++) begin
            @(negedge clk);
            if (Tx_WR) nwr++;
        end
        chk("reset_reached_byte2", nwr, 3);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (Tx_BUSY) break;
        end
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        req_a = 1'b0;
        exp_bytes.delete();
        exp_done.delete();
        m_last_b = 1'b1;
        #1;
        chk("midrst_tx_wr", Tx_WR, 0);
        chk("midrst_tx_data", Tx_DATA, 0);
        chk("midrst_seq_busy", seq_busy, 0);
        chk("midrst_baud", baud_select, 3'b010);
        chk("midrst_done", {done_b, done_a, timeout_err}, 0);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        for (int t = 0; t < 100 && Tx_BUSY; t++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        run_pair(1, 0, $urandom, 32'h0, 3'b100, 0);

        // Randomized request patterns
        tx_blen = 0;
        for (int it = 0; it < 12; it++) begin
            pat = 2'($urandom_range(1, 3));
            run_pair(pat[0], pat[1], $urandom, $urandom, 3'($urandom_range(0, 7)), 0);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        repeat (20) begin @(posedge clk); #1; end
        chk("bytes_drained", exp_bytes.size(), 0);
        chk("dones_drained", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
